// File: rtl/packet_scheduler.sv
// Data-island packet scheduler: buffers stereo audio, tracks ACR/InfoFrame requests and
// picks the packet for each 32-cycle slot by fixed priority, holding it while hdmi sends it.
module packet_scheduler #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int ACR_PERIOD      = 27000
) (
  input  logic                                clk_pixel,
  input  logic                                reset_n,
  input  logic                                audio_in_valid,
  output logic                                audio_in_ready,
  input  logic [1:0][AUDIO_BIT_WIDTH-1:0]     audio_in_word,
  input  logic                                frame_start,
  input  logic                                packet_enable,
  output logic [7:0]                          packet_type,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0]     audio_sample_word,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(ACR_PERIOD);

  localparam logic [7:0]    PT_NULL  = 8'h00;
  localparam logic [7:0]    PT_ACR   = 8'h01;
  localparam logic [7:0]    PT_AUDIO = 8'h02;
  localparam logic [7:0]    PT_AVI   = 8'h82;
  localparam logic [7:0]    PT_AIF   = 8'h84;

  localparam logic [TW-1:0] ACR_LAST = TW'(ACR_PERIOD - 1);
  localparam logic [TW-1:0] ACR_ONE  = TW'(1);
  localparam logic [TW-1:0] ACR_ZERO = TW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [1:0][AUDIO_BIT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]                   wr_ptr_r;
  logic [PW-1:0]                   rd_ptr_r;
  logic [LW-1:0]                   level_r;
  logic [LW-1:0]                   level_next_s;
  logic                            ready_r;
  logic [TW-1:0]                   acr_cnt_r;
  logic                            avi_pend_r;
  logic                            aif_pend_r;
  logic                            acr_pend_r;
  logic [4:0]                      lock_cnt_r;
  logic [7:0]                      packet_type_r;
  logic [1:0][AUDIO_BIT_WIDTH-1:0] sample_word_r;
  logic [7:0]                      sel_s;
  logic                            commit_s;
  logic                            update_s;
  logic                            push_s;
  logic                            pop_s;
  logic                            acr_wrap_s;

  assign commit_s   = packet_enable && (lock_cnt_r == 5'd0);
  // The edge ending the last locked cycle re-evaluates so the next slot sees fresh data.
  assign update_s   = !commit_s && (lock_cnt_r <= 5'd1);
  assign pop_s      = commit_s && (packet_type_r == PT_AUDIO);
  assign push_s     = audio_in_valid && ready_r;
  assign acr_wrap_s = (acr_cnt_r == ACR_LAST);

  assign audio_in_ready    = ready_r;
  assign fifo_level        = level_r;
  assign packet_type       = packet_type_r;
  assign audio_sample_word = sample_word_r;

  // Fixed-priority selection from the current pending state.
  always_comb begin
    sel_s = PT_NULL;
    if (avi_pend_r) begin
      sel_s = PT_AVI;
    end else if (aif_pend_r) begin
      sel_s = PT_AIF;
    end else if (acr_pend_r) begin
      sel_s = PT_ACR;
    end else if (level_r != LVL_ZERO) begin
      sel_s = PT_AUDIO;
    end else begin
      sel_s = PT_NULL;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk_pixel) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= audio_in_word;
    end
  end

  // FIFO pointers, level and ready flag.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_next_s;
      ready_r <= (level_next_s != LVL_FULL);
    end
  end

  // ACR timer and request flags; a new request outranks a same-cycle retire.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_cnt_r  <= ACR_ZERO;
      avi_pend_r <= 1'b0;
      aif_pend_r <= 1'b0;
      acr_pend_r <= 1'b0;
    end else begin
      acr_cnt_r  <= acr_wrap_s ? ACR_ZERO : (acr_cnt_r + ACR_ONE);
      avi_pend_r <= frame_start || (avi_pend_r && !(commit_s && (packet_type_r == PT_AVI)));
      aif_pend_r <= frame_start || (aif_pend_r && !(commit_s && (packet_type_r == PT_AIF)));
      acr_pend_r <= acr_wrap_s  || (acr_pend_r && !(commit_s && (packet_type_r == PT_ACR)));
    end
  end

  // Slot lock and the registered packet outputs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_r    <= 5'd0;
      packet_type_r <= PT_NULL;
      sample_word_r <= {(2*AUDIO_BIT_WIDTH){1'b0}};
    end else begin
      if (commit_s) begin
        lock_cnt_r <= 5'd31;
      end else if (lock_cnt_r != 5'd0) begin
        lock_cnt_r <= lock_cnt_r - 5'd1;
      end
      if (update_s) begin
        packet_type_r <= sel_s;
        if (sel_s == PT_AUDIO) begin
          sample_word_r <= mem_r[rd_ptr_r];
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: expected slot contents are queued as strobes are
// issued and a monitor checks packet_type/audio_sample_word on every counted strobe.
module tb_packet_scheduler;

  logic             clk_pixel = 1'b0;
  logic             reset_n;
  logic             audio_in_valid;
  logic             audio_in_ready;
  logic [1:0][15:0] audio_in_word;
  logic             frame_start;
  logic             packet_enable;
  logic [7:0]       packet_type;
  logic [1:0][15:0] audio_sample_word;
  logic [3:0]       fifo_level;

  typedef struct packed {
    logic [7:0]  t;
    logic [31:0] w;
    logic        cw;
  } slot_t;

  slot_t exp_q[$];
  slot_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    stray   = 1'b0;

  packet_scheduler #(
    .AUDIO_BIT_WIDTH(16),
    .FIFO_DEPTH(8),
    .ACR_PERIOD(27000)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .audio_in_valid(audio_in_valid),
    .audio_in_ready(audio_in_ready),
    .audio_in_word(audio_in_word),
    .frame_start(frame_start),
    .packet_enable(packet_enable),
    .packet_type(packet_type),
    .audio_sample_word(audio_sample_word),
    .fifo_level(fifo_level)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Monitor: every counted strobe must match the next queued slot.
  always @(negedge clk_pixel) begin
    if (reset_n === 1'b1 && packet_enable === 1'b1 && !stray) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL slot_unexpected: packet_type=%h, no slot queued", packet_type);
      end else begin
        mon_e = exp_q.pop_front();
        if (packet_type !== mon_e.t || (mon_e.cw && audio_sample_word !== mon_e.w)) begin
          n_fail++;
          $display("FAIL slot: type=%h word=%h, expected type=%h word=%h",
                   packet_type, audio_sample_word, mon_e.t, mon_e.w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic slot(input logic [7:0] t, input logic [31:0] w, input logic cw);
    slot_t s;
    s.t = t;
    s.w = w;
    s.cw = cw;
    exp_q.push_back(s);
    packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    audio_in_valid = 1'b0;
    audio_in_word  = 32'h0;
    frame_start    = 1'b0;
    packet_enable  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] w);
    audio_in_valid = 1'b1;
    audio_in_word  = w;
    tick();
    audio_in_valid = 1'b0;
  endtask

  logic [31:0] t3w [3];
  logic [7:0]  t3t [7];
  logic [31:0] s4  [9];

  initial begin
    // Test 1: reset values and first ACR request.
    do_reset();
    check("rst_type", packet_type, 32'h00);
    check("rst_ready", audio_in_ready, 32'h1);
    check("rst_level", fifo_level, 32'h0);
    check("rst_word", audio_sample_word, 32'h0);
    tick();
    check("idle_type", packet_type, 32'h00);
    repeat (26999) tick();
    check("acr_before", packet_type, 32'h00);
    tick();
    check("acr_after", packet_type, 32'h01);

    // Test 2: single sample, held for a whole slot.
    do_reset();
    push(32'hABCD_1234);
    check("t2_level1", fifo_level, 32'h1);
    check("t2_type_pre", packet_type, 32'h00);
    tick();
    check("t2_type", packet_type, 32'h02);
    check("t2_word", audio_sample_word, 32'hABCD_1234);
    slot(8'h02, 32'hABCD_1234, 1'b1);
    check("t2_level0", fifo_level, 32'h0);
    check("t2_hold", packet_type, 32'h02);
    for (int i = 0; i < 30; i++) begin
      tick();
      check("t2_hold", packet_type, 32'h02);
    end
    tick();
    check("t2_next_null", packet_type, 32'h00);
    check("t2_word_keep", audio_sample_word, 32'hABCD_1234);
    slot(8'h00, 32'h0, 1'b0);
    repeat (31) tick();

    // Test 3: priority order across slots.
    t3w[0] = 32'h1111_0001;
    t3w[1] = 32'h2222_0002;
    t3w[2] = 32'h3333_0003;
    t3t[0] = 8'h82; t3t[1] = 8'h84; t3t[2] = 8'h01; t3t[3] = 8'h02;
    t3t[4] = 8'h02; t3t[5] = 8'h02; t3t[6] = 8'h00;
    do_reset();
    repeat (27000) tick();
    for (int i = 0; i < 3; i++) push(t3w[i]);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("t3_first", packet_type, 32'h82);
    check("t3_level", fifo_level, 32'h3);
    for (int i = 0; i < 7; i++) begin
      slot(t3t[i], (i >= 3 && i <= 5) ? t3w[i-3] : 32'h0, (i >= 3 && i <= 5));
      repeat (31) tick();
    end

    // Test 4: fill to depth, back-pressure, then drain in order.
    for (int i = 0; i < 9; i++) s4[i] = 32'h4000_0000 + 32'(i * 32'h0001_0001);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check("t4_ready_fill", audio_in_ready, 32'h1);
      push(s4[i]);
    end
    check("t4_full_ready", audio_in_ready, 32'h0);
    check("t4_full_level", fifo_level, 32'h8);
    audio_in_valid = 1'b1;
    audio_in_word  = s4[8];
    repeat (3) tick();
    check("t4_held_off", fifo_level, 32'h8);
    slot(8'h02, s4[0], 1'b1);
    check("t4_pop_level", fifo_level, 32'h7);
    check("t4_pop_ready", audio_in_ready, 32'h1);
    tick();
    audio_in_valid = 1'b0;
    check("t4_ninth_in", fifo_level, 32'h8);
    check("t4_ninth_ready", audio_in_ready, 32'h0);
    repeat (30) tick();
    for (int i = 1; i < 9; i++) begin
      slot(8'h02, s4[i], 1'b1);
      repeat (31) tick();
    end
    check("t4_drained", fifo_level, 32'h0);
    slot(8'h00, 32'h0, 1'b0);
    repeat (31) tick();

    // Test 5: frame_start during an AVI commit re-arms AVI.
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    frame_start = 1'b1;
    slot(8'h82, 32'h0, 1'b0);
    frame_start = 1'b0;
    repeat (31) tick();
    slot(8'h82, 32'h0, 1'b0);
    repeat (31) tick();
    slot(8'h84, 32'h0, 1'b0);
    repeat (31) tick();
    slot(8'h00, 32'h0, 1'b0);
    repeat (31) tick();

    // Test 6: stray strobe inside a slot, then reset mid-slot.
    do_reset();
    push(32'h6666_0001);
    push(32'h6666_0002);
    tick();
    slot(8'h02, 32'h6666_0001, 1'b1);
    repeat (4) tick();
    stray = 1'b1;
    packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0;
    stray = 1'b0;
    check("t6_stray_level", fifo_level, 32'h1);
    check("t6_stray_word", audio_sample_word, 32'h6666_0001);
    repeat (4) tick();
    check("t6_pre_reset", packet_type, 32'h02);
    reset_n = 1'b0;
    #1;
    check("t6_rst_type", packet_type, 32'h00);
    check("t6_rst_level", fifo_level, 32'h0);
    check("t6_rst_ready", audio_in_ready, 32'h1);
    check("t6_rst_word", audio_sample_word, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_post_type", packet_type, 32'h00);
    check("t6_post_level", fifo_level, 32'h0);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
